// File: rtl/grid_frame_streamer.sv
// grid_frame_streamer
//
// Single-clock frame path between the grid logic and an external LED driver.
// A start edge (or, in continuous mode, an idle timer expiry) produces one
// grid_step pulse. After a settle window the grid is snapshotted and streamed
// out OUT_W bits per rising edge of the consumer strobe ext_clk.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous active-high reset
//   start          in   asynchronous frame request (rising edge used)
//   continuous     in   enables periodic frame triggering
//   ext_clk        in   asynchronous consumer strobe (rising edge used)
//   grid_in        in   ROWS*COLS grid, cell (r,c) at bit r*COLS+c
//   grid_step      out  one-cycle pulse advancing the grid logic
//   led_out        out  current output word
//   stream_active  out  high while a frame is being streamed
//   frame_done     out  one-cycle pulse at end of frame
//   word_index     out  index of the word on led_out

module grid_frame_streamer #(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned CONT_DIV = 1000000,
  localparam int unsigned GW      = ROWS * COLS,
  localparam int unsigned NWORDS  = GW / OUT_W,
  localparam int unsigned IW      = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             ext_clk,
  input  logic [GW-1:0]    grid_in,
  output logic             grid_step,
  output logic [OUT_W-1:0] led_out,
  output logic             stream_active,
  output logic             frame_done,
  output logic [IW-1:0]    word_index
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CW = $clog2(CONT_DIV);

  typedef enum logic [2:0] {
    StIdle,
    StStep,
    StSettle,
    StStream,
    StDone
  } state_e;

  state_e state_q, state_d;

  // [0] first sync flop, [1] sync2, [2] sync3 (edge-detect history)
  logic [2:0] start_sync_q, ext_sync_q;
  logic       start_rise, ext_rise;

  logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [GW-1:0]    shadow_q, shadow_d;
  logic [OUT_W-1:0] led_q, led_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             active_q, active_d;
  logic             step_q, step_d;
  logic             done_q, done_d;

  logic             timer_hit;
  logic [IW-1:0]    next_idx;
  logic [GW-1:0]    word_shift;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_sync_q <= '0;
      ext_sync_q   <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start};
      ext_sync_q   <= {ext_sync_q[1:0], ext_clk};
    end
  end

  assign start_rise = start_sync_q[1] & ~start_sync_q[2];
  assign ext_rise   = ext_sync_q[1] & ~ext_sync_q[2];

  assign timer_hit  = continuous && (idle_cnt_q == CW'(CONT_DIV - 1));
  assign next_idx   = idx_q + IW'(1);
  assign word_shift = shadow_q >> (OUT_W * 32'(next_idx));

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = '0;
    settle_cnt_d = '0;
    shadow_d     = shadow_q;
    led_d        = led_q;
    idx_d        = idx_q;
    active_d     = active_q;
    step_d       = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A simultaneous start edge and timer expiry still yields one frame.
        if (start_rise || timer_hit) begin
          state_d = StStep;
          step_d  = 1'b1;
        end else if (continuous) begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      StStep: begin
        state_d = StSettle;
      end
      StSettle: begin
        if (settle_cnt_q == SW'(SETTLE - 1)) begin
          state_d  = StStream;
          shadow_d = grid_in;
          led_d    = grid_in[OUT_W-1:0];
          idx_d    = '0;
          active_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      StStream: begin
        if (ext_rise) begin
          if (idx_q < IW'(NWORDS - 1)) begin
            idx_d = next_idx;
            led_d = word_shift[OUT_W-1:0];
          end else begin
            state_d  = StDone;
            active_d = 1'b0;
            led_d    = '0;
            idx_d    = '0;
            done_d   = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idle_cnt_q   <= '0;
      settle_cnt_q <= '0;
      shadow_q     <= '0;
      led_q        <= '0;
      idx_q        <= '0;
      active_q     <= 1'b0;
      step_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      shadow_q     <= shadow_d;
      led_q        <= led_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      step_q       <= step_d;
      done_q       <= done_d;
    end
  end

  assign grid_step     = step_q;
  assign led_out       = led_q;
  assign stream_active = active_q;
  assign frame_done    = done_q;
  assign word_index    = idx_q;

endmodule

// File: tb/tb_grid_frame_streamer.sv
module tb_grid_frame_streamer;

  localparam int unsigned ROWS     = 4;
  localparam int unsigned COLS     = 4;
  localparam int unsigned OUT_W    = 8;
  localparam int unsigned SETTLE   = 2;
  localparam int unsigned CONT_DIV = 10;
  localparam int unsigned GW       = ROWS * COLS;
  localparam int unsigned NW       = GW / OUT_W;
  localparam int unsigned IW       = 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic             ext_man = 1'b0;
  logic             ext_auto = 1'b0;
  logic             auto_en = 1'b0;
  logic             ext_clk;
  logic [GW-1:0]    grid_in = '0;
  logic             grid_step, stream_active, frame_done;
  logic [OUT_W-1:0] led_out;
  logic [IW-1:0]    word_index;

  assign ext_clk = ext_man | ext_auto;

  always #5 clock = ~clock;

  grid_frame_streamer #(
    .ROWS(ROWS), .COLS(COLS), .OUT_W(OUT_W), .SETTLE(SETTLE), .CONT_DIV(CONT_DIV)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous),
    .ext_clk(ext_clk), .grid_in(grid_in), .grid_step(grid_step), .led_out(led_out),
    .stream_active(stream_active), .frame_done(frame_done), .word_index(word_index)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: inputs seen through a 2-cycle sampling delay, frame
  // phases tracked by timestamps, the frame kept as a list of words.
  int             m_mode = 0;  // 0 idle, 1 step/settle, 2 streaming, 3 done
  logic [3:0]     hs = '0, he = '0;
  int             t_now = 0, t_snap = 0, t_stream = 0, idle_run = 0;
  logic [OUT_W-1:0] m_words[NW];
  int             e_idx = 0;
  logic           e_step = 0, e_act = 0, e_done = 0;
  logic [OUT_W-1:0] e_led = '0;
  int             m_lens[$];

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        hs = '0; he = '0; m_mode = 0; idle_run = 0;
        e_step = 0; e_act = 0; e_done = 0; e_led = '0; e_idx = 0;
        for (int i = 0; i < NW; i++) m_words[i] = '0;
      end else begin
        t_now++;
        hs = {hs[2:0], start};
        he = {he[2:0], ext_clk};
        e_step = 0;
        e_done = 0;
        case (m_mode)
          0: begin
            if ((hs[2] && !hs[3]) || (continuous && idle_run == CONT_DIV - 1)) begin
              m_mode = 1; e_step = 1; idle_run = 0;
              t_snap = t_now + 1 + SETTLE;
            end else idle_run = continuous ? idle_run + 1 : 0;
          end
          1: begin
            if (t_now == t_snap) begin
              for (int i = 0; i < NW; i++) m_words[i] = grid_in[i*OUT_W +: OUT_W];
              e_led = m_words[0]; e_idx = 0; e_act = 1;
              m_mode = 2; t_stream = t_now;
            end
          end
          2: begin
            if (he[2] && !he[3]) begin
              if (e_idx < NW - 1) begin
                e_idx++;
                e_led = m_words[e_idx];
              end else begin
                m_mode = 3; e_act = 0; e_led = '0; e_idx = 0; e_done = 1;
                m_lens.push_back(t_now - t_stream);
              end
            end
          end
          default: begin
            m_mode = 0; idle_run = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle compare against the model, plus a grid_step rise monitor.
  int   step_count = 0;
  int   step_times[$];
  logic prev_step = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      check("grid_step", grid_step, e_step);
      check("stream_active", stream_active, e_act);
      check("frame_done", frame_done, e_done);
      check("led_out", led_out, e_led);
      check("word_index", word_index, e_idx);
      if (grid_step && !prev_step) begin
        step_count++;
        step_times.push_back(cyc);
      end
      prev_step = grid_step;
    end
  end

  // Consumer strobe generator: 3 cycles high, 3 low.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clock);
      if (auto_en) begin
        ext_auto = (ph % 6) < 3;
        ph++;
      end else begin
        ext_auto = 1'b0;
        ph = 0;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic at_edge(int k);
    while (cyc < k) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, s, t, c0;

    // Reset with random inputs.
    repeat (3) begin
      @(negedge clock);
      start = 1'($urandom_range(0, 1));
      continuous = 1'($urandom_range(0, 1));
      ext_man = 1'($urandom_range(0, 1));
      grid_in = GW'($urandom);
    end
    @(negedge clock);
    check("rst_step", grid_step, 0);
    check("rst_led", led_out, 0);
    check("rst_active", stream_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_idx", word_index, 0);
    start = 0; continuous = 0; ext_man = 0; grid_in = '0;
    @(negedge clock);
    reset = 0;
    s = step_count;
    tick(50);
    check("idle_no_step", step_count, s);

    // Directed frame A55A.
    @(negedge clock);
    grid_in = 16'hA55A; start = 1; n = cyc + 1;
    at_edge(n + 2);
    check("step_n2", grid_step, 1);
    start = 0;
    at_edge(n + 3);
    check("step_n3", grid_step, 0);
    at_edge(n + 4);
    check("active_n4", stream_active, 0);
    at_edge(n + 5);
    check("active_n5", stream_active, 1);
    check("led_w0", led_out, 8'h5A);
    check("idx_w0", word_index, 0);
    grid_in = 16'hFFFF;
    tick(2);
    ext_man = 1; m = cyc + 1;
    at_edge(m + 1);
    check("led_before_act", led_out, 8'h5A);
    at_edge(m + 2);
    check("led_w1", led_out, 8'hA5);
    check("idx_w1", word_index, 1);
    ext_man = 0;
    tick(2);
    s = step_count;
    start = 1;
    tick(3);
    start = 0;
    tick(4);
    check("no_restep_in_stream", step_count, s);
    check("still_w1", led_out, 8'hA5);
    ext_man = 1; m = cyc + 1;
    at_edge(m + 2);
    check("end_active", stream_active, 0);
    check("end_led", led_out, 0);
    check("end_done", frame_done, 1);
    ext_man = 0;
    at_edge(m + 3);
    check("done_one_cycle", frame_done, 0);
    tick(3);

    // Strobe while idle.
    s = step_count;
    repeat (2) begin
      ext_man = 1; tick(3); ext_man = 0; tick(3);
    end
    check("idle_ext_led", led_out, 0);
    check("idle_ext_active", stream_active, 0);
    check("idle_ext_step", step_count, s);

    // Continuous mode.
    grid_in = 16'h3C96;
    step_times.delete();
    m_lens.delete();
    @(negedge clock);
    continuous = 1; auto_en = 1; c0 = cyc + 1;
    t = 0;
    while (step_times.size() < 3 && t < 600) begin
      @(negedge clock);
      t++;
    end
    check("cont_three_frames", step_times.size() >= 3, 1);
    if (step_times.size() >= 3 && m_lens.size() >= 2) begin
      check("cont_first_step", step_times[0], c0 + CONT_DIV - 1);
      for (int k = 0; k < 2; k++)
        check("cont_period", step_times[k+1] - step_times[k],
              CONT_DIV + 1 + SETTLE + m_lens[k] + 1);
    end
    t = 0;
    while (!stream_active && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("cont_stream_seen", stream_active, 1);
    continuous = 0;
    t = 0;
    while (!frame_done && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("cont_frame_completes", frame_done, 1);
    s = step_count;
    tick(40);
    check("cont_stopped", step_count, s);
    auto_en = 0;
    tick(4);

    // Reset mid-frame, then a full frame.
    grid_in = 16'h1234;
    @(negedge clock);
    start = 1; n = cyc + 1;
    at_edge(n + 2);
    start = 0;
    at_edge(n + 5);
    ext_man = 1; m = cyc + 1;
    at_edge(m + 2);
    ext_man = 0;
    check("pre_reset_idx", word_index, 1);
    check("pre_reset_led", led_out, 8'h12);
    @(posedge clock);
    #2 reset = 1;
    #1;
    check("async_rst_active", stream_active, 0);
    check("async_rst_led", led_out, 0);
    check("async_rst_idx", word_index, 0);
    @(negedge clock);
    reset = 0;
    tick(3);
    @(negedge clock);
    start = 1; n = cyc + 1;
    at_edge(n + 2);
    start = 0;
    at_edge(n + 5);
    check("re_w0_led", led_out, 8'h34);
    check("re_w0_idx", word_index, 0);
    ext_man = 1; m = cyc + 1;
    at_edge(m + 2);
    ext_man = 0;
    check("re_w1_led", led_out, 8'h12);
    tick(3);
    ext_man = 1; m = cyc + 1;
    at_edge(m + 2);
    ext_man = 0;
    check("re_done", frame_done, 1);
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid_frame_streamer.md
# grid_frame_streamer

Parametrised successor to the top-level frame path between the Tetris grid logic and the external LED driver (Arduino). On a start request or a periodic timer, the block issues one game-step pulse to the grid and waits a settle window. It then snapshots the ROWS×COLS grid and streams it out OUT_W bits at a time, one word per rising edge of the consumer's strobe. All `#` delays and multi-clock sequencing in the top level are replaced by a synthesisable single-clock FSM.

## Interface
- ROWS, 16, grid rows.
- COLS, 16, grid columns.
- OUT_W, 8, output word width; ROWS*COLS must be a multiple of OUT_W.
- SETTLE, 2, clock cycles between grid_step and snapshot; must be ≥1.
- CONT_DIV, 1000000, idle clock cycles between frames in continuous mode; must be ≥2.
- Derived: NWORDS = ROWS*COLS/OUT_W; IW = max(1, clog2(NWORDS)).

Ports:
- clock  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  asynchronous frame request; its rising edge is used.
- continuous  in  1  when 1, frames are also triggered periodically.
- ext_clk  in  1  asynchronous consumer strobe (arduinoClock); its rising edge is used.
- grid_in  in  ROWS*COLS  grid state; cell (r,c) is at bit r*COLS+c.
- grid_step  out  1  one-cycle pulse that advances the grid logic.
- led_out  out  OUT_W  current output word.
- stream_active  out  1  high while a frame is being streamed (arduinoStart).
- frame_done  out  1  one-cycle pulse at the end of a frame.
- word_index  out  IW  index of the word currently on led_out.

## Operation
- start and ext_clk each pass through a 2-flop synchroniser and a rising-edge detector (sync2 & ~sync3). All logic is in the clock domain.
- FSM states: IDLE, STEP, SETTLE, STREAM, DONE.
- IDLE → STEP on a trigger. A trigger is either a start edge or, when continuous=1, idle_cnt == CONT_DIV-1.
- idle_cnt increments only in IDLE while continuous=1. It clears on leaving IDLE and whenever continuous=0.
- STEP lasts one cycle with grid_step=1, then goes to SETTLE.
- SETTLE lasts exactly SETTLE cycles. On the exit edge:
  - shadow ← grid_in;
  - led_out ← grid_in[OUT_W-1:0];
  - word_index ← 0;
  - stream_active ← 1;
  - state → STREAM.
- STREAM, on each ext_clk edge:
  - if word_index < NWORDS-1: word_index++ and led_out ← shadow[(word_index+1)*OUT_W +: OUT_W];
  - else: state → DONE, stream_active ← 0, led_out ← 0, word_index ← 0.
- DONE lasts one cycle with frame_done=1, then returns to IDLE.
- Word order: word 0 first; the LSB slice is row 0 first.
- Once the snapshot is taken, grid_in changes have no effect until the next frame.
- start edges outside IDLE are ignored and are not queued.
- ext_clk edges outside STREAM are ignored.
- Clearing continuous mid-frame lets the frame complete.
- If a start edge and a timer expiry occur in the same cycle, exactly one frame is started.
- NWORDS=1: the first ext_clk edge in STREAM ends the frame.
- reset forces IDLE immediately, at any point including mid-frame. It clears all outputs, idle_cnt, synchronisers and the shadow register.

## Timing
- Reset values: grid_step=0, led_out=0, stream_active=0, frame_done=0, word_index=0.
- A start or ext_clk that is first sampled high at clock edge n is acted on at edge n+2.
- A start first sampled high at edge n:
  - grid_step is high from edge n+2 to edge n+3;
  - the snapshot is taken and stream_active rises at edge n+3+SETTLE.
- An ext_clk first sampled high at edge n updates led_out and word_index at edge n+2.
- The consumer must hold ext_clk high and low for ≥2 clock periods each.
- Frame end: frame_done is high for exactly the one cycle after stream_active falls.
- Continuous period: CONT_DIV idle cycles, plus 1+SETTLE cycles, plus the streaming time, plus 1 cycle (DONE).
- All outputs are registered.

## Test plan
Bench parameters: ROWS=4, COLS=4, OUT_W=8, SETTLE=2, CONT_DIV=10 (NWORDS=2).
- Reset with random inputs → all outputs 0. Release reset with start=0 and continuous=0 for 50 cycles → no grid_step.
- grid_in=16'hA55A, start sampled high at edge n → grid_step high edges n+2..n+3; at edge n+5, stream_active=1 and led_out=8'h5A.
  - First ext_clk edge → led_out=8'hA5, word_index=1.
  - Second ext_clk edge → stream_active=0, led_out=0, then a one-cycle frame_done.
- Change grid_in to 16'hFFFF during STREAM → streamed words remain 5A, A5. Pulse start during STREAM → no second grid_step. Toggle ext_clk in IDLE → led_out stays 0.
- continuous=1 with consumer strobes auto-generated → grid_step pulses exactly CONT_DIV+1+SETTLE+stream+1 cycles apart over 3 frames. Clear continuous mid-frame → that frame completes and no further frames start.
- Assert reset after the first ext_clk edge of a frame → outputs 0 asynchronously. A new start afterwards streams a full frame from word 0.
